dmem_bist: RTL and testbench

Built-in self-test initiator for the data memory (`dmem`): 12-bit word address, 32-bit data, write enable, synchronous read. On `start` it drives the memory through four phases:

- write pass of a multiplicative pattern;
- read-back and compare;
- write pass of the inverted pattern;
- read-back and compare.

It then reports pass/fail, an error count and the first failing address/data. It sits between the processor-side memory mux and `dmem`, owning the port while `busy` is high.

---
 rtl/dmem_bist.sv | 190 +++++++++++++++++++
 tb/tb_dmem_bist.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dmem_bist.sv
// dmem_bist: memory self-test; writes P(a)=a*MULT, reads it back and compares, then repeats with ~P(a), and reports.
// Latency: first write appears the cycle after start; a run lasts 4*N + 2*READ_LAT cycles; each compare lands READ_LAT cycles after its read.
// Backpressure: none; issues one access per cycle and assumes dmem is always ready; start is ignored while busy.
module dmem_bist #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int ADDR_STEP = 2,
    parameter int ADDR_LAST = 4000,
    parameter int MULT      = 28937,
    parameter int READ_LAT  = 1
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [2:0] {
        S_IDLE, S_W0, S_R0, S_D0, S_W1, S_R1, S_D1, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(ADDR_LAST);
    localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(ADDR_STEP);
    // P(a+STEP) = P(a) + STEP*MULT (mod 2^DATA_W), so the pattern is accumulated instead of multiplied.
    localparam logic [DATA_W-1:0] PAT_STEP = DATA_W'(ADDR_STEP) * DATA_W'(MULT);
    localparam int                DRN_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(READ_LAT - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_nxt, addr_inc;
    logic [DATA_W-1:0]   pat_reg, pat_nxt;
    logic [DATA_W-1:0]   data_nxt, issue_exp;
    logic [DRN_W-1:0]    drain_cnt, drain_nxt;
    logic                wren_nxt, inv_nxt, issue, clear, at_last;
    logic                busy_nxt, done_nxt, pass_nxt, cmp_hit;
    logic [15:0]         err_nxt;
    logic [ADDR_W-1:0]   faddr_nxt;
    logic [DATA_W-1:0]   fdata_nxt;

    // Read-compare pipeline: one slot per cycle of memory latency.
    logic                pipe_vld  [READ_LAT];
    logic [ADDR_W-1:0]   pipe_addr [READ_LAT];
    logic [DATA_W-1:0]   pipe_exp  [READ_LAT];

    assign addr_inc  = mem_address + STEP_A;
    assign at_last   = (mem_address == LAST_A);
    assign issue_exp = (state == S_R1) ? ~pat_reg : pat_reg;

    // State register plus the registered memory-port and status outputs.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state          <= S_IDLE;
            pat_reg        <= '0;
            drain_cnt      <= '0;
            mem_address    <= '0;
            mem_data       <= '0;
            mem_wren       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            state          <= state_nxt;
            pat_reg        <= pat_nxt;
            drain_cnt      <= drain_nxt;
            mem_address    <= addr_nxt;
            mem_data       <= data_nxt;
            mem_wren       <= wren_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            err_count      <= err_nxt;
            first_err_addr <= faddr_nxt;
            first_err_data <= fdata_nxt;
        end
    end

    // Next state and next access; mem_* show the access of the state being entered.
    always_comb begin
        state_nxt = state;
        addr_nxt  = mem_address;
        pat_nxt   = pat_reg;
        wren_nxt  = 1'b0;
        inv_nxt   = 1'b0;
        drain_nxt = '0;
        issue     = 1'b0;
        clear     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_W0;
                    addr_nxt  = '0;
                    pat_nxt   = '0;
                    wren_nxt  = 1'b1;
                    clear     = 1'b1;
                end
            end
            S_W0, S_W1: begin
                if (at_last) begin
                    state_nxt = (state == S_W0) ? S_R0 : S_R1;
                    addr_nxt  = '0;
                    pat_nxt   = '0;
                end else begin
                    addr_nxt  = addr_inc;
                    pat_nxt   = pat_reg + PAT_STEP;
                    wren_nxt  = 1'b1;
                    inv_nxt   = (state == S_W1);
                end
            end
            S_R0, S_R1: begin
                issue = 1'b1;
                if (at_last) begin
                    state_nxt = (state == S_R0) ? S_D0 : S_D1;
                    addr_nxt  = '0;
                    pat_nxt   = '0;
                end else begin
                    addr_nxt  = addr_inc;
                    pat_nxt   = pat_reg + PAT_STEP;
                end
            end
            S_D0, S_D1: begin
                // Address/pattern already sit at 0, ready for the next write pass.
                if (drain_cnt == DRN_LAST) begin
                    if (state == S_D0) begin
                        state_nxt = S_W1;
                        wren_nxt  = 1'b1;
                        inv_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    drain_nxt = drain_cnt + DRN_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        data_nxt = wren_nxt ? (inv_nxt ? ~pat_nxt : pat_nxt) : '0;
        busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        done_nxt = (state_nxt == S_DONE);
    end

    // Carry address and expected value alongside each read until mem_q is valid.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < READ_LAT; i++) pipe_vld[i] <= 1'b0;
        end else begin
            pipe_vld[0] <= issue;
            for (int i = 1; i < READ_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
        pipe_addr[0] <= mem_address;
        pipe_exp[0]  <= issue_exp;
        for (int i = 1; i < READ_LAT; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_exp[i]  <= pipe_exp[i-1];
        end
    end

    assign cmp_hit = pipe_vld[READ_LAT-1] && (mem_q != pipe_exp[READ_LAT-1]);

    // Error bookkeeping: saturating count, first failure captured only once per run.
    always_comb begin
        err_nxt   = err_count;
        faddr_nxt = first_err_addr;
        fdata_nxt = first_err_data;
        if (clear) begin
            err_nxt   = '0;
            faddr_nxt = '0;
            fdata_nxt = '0;
        end else if (cmp_hit) begin
            if (err_count != 16'hFFFF) err_nxt = err_count + 16'd1;
            if (err_count == 16'd0) begin
                faddr_nxt = pipe_addr[READ_LAT-1];
                fdata_nxt = mem_q;
            end
        end
        pass_nxt = done_nxt && (err_nxt == 16'd0);
    end

endmodule

// File: tb/tb_dmem_bist.sv
module tb_dmem_bist;

    logic        clock = 1'b0;
    logic        ctrl_reset, start;
    logic        busy, done, pass, mem_wren;
    logic [15:0] err_count;
    logic [11:0] first_err_addr, mem_address;
    logic [31:0] first_err_data, mem_data, mem_q;

    int errors = 0;
    int checks = 0;

    dmem_bist dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(start),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // 0 = ideal, 1 = data bit 5 stuck at 0, 2 = address bit 11 ignored
    int          fault_mode = 0;
    logic [31:0] mem [0:4095];

    function automatic logic [11:0] eff(input logic [11:0] a);
        return (fault_mode == 2) ? (a & 12'h7FF) : a;
    endfunction

    function automatic logic [31:0] pat(input int a);
        return 32'(a) * 32'd28937;
    endfunction

    // dmem model with one cycle read latency
    always @(posedge clock) begin
        if (mem_wren === 1'b1)
            mem[eff(mem_address)] <= (fault_mode == 1) ? (mem_data & ~32'h20) : mem_data;
        mem_q <= mem[eff(mem_address)];
    end

    typedef struct { logic [11:0] addr; logic [31:0] data; } w_t;
    typedef struct { logic [15:0] err; logic [11:0] faddr; logic [31:0] fdata; logic pass; } res_t;
    typedef struct { int mode; bit mid; logic [15:0] err; logic [11:0] faddr; logic [31:0] fdata; logic pass; } vec_t;

    w_t   wq[$];
    res_t rq[$];
    int   wr_cnt = 0;
    int   wr_bad = 0;

    // write scoreboard: every write must match the next expected (address, data)
    always @(negedge clock) begin
        if (mem_wren === 1'b1) begin
            wr_cnt++;
            if (wq.size() == 0) wr_bad++;
            else begin
                w_t w;
                w = wq.pop_front();
                if (w.addr !== mem_address || w.data !== mem_data) wr_bad++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_test(input vec_t v);
        int   cyc;
        res_t r;
        fault_mode = v.mode;
        wq.delete();
        wr_cnt = 0;
        wr_bad = 0;
        for (int a = 0; a <= 4000; a += 2) wq.push_back('{12'(a), pat(a)});
        for (int a = 0; a <= 4000; a += 2) wq.push_back('{12'(a), ~pat(a)});
        rq.push_back('{v.err, v.faddr, v.fdata, v.pass});
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        check("start_busy", busy, 1);
        check("start_first_write", {mem_wren, mem_address, mem_data}, {1'b1, 12'd0, 32'd0});
        check("start_clears", {done, pass, err_count, first_err_addr, first_err_data}, 0);
        cyc = 0;
        while (cyc < 9000) begin
            @(negedge clock);
            if (busy !== 1'b1) break;
            cyc++;
            start = (v.mid && cyc == 50) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check("busy_cycles", cyc, 8006);
        r = rq.pop_front();
        check("done", done, 1);
        check("pass", pass, r.pass);
        check("err_count", err_count, r.err);
        check("first_err_addr", first_err_addr, r.faddr);
        check("first_err_data", first_err_data, r.fdata);
        check("write_count", wr_cnt, 4002);
        check("write_mismatches", wr_bad, 0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{0, 1'b0, 16'd0,    12'd0, 32'd0,                  1'b1};
        vecs[1] = '{1, 1'b0, 16'd2001, 12'd4, pat(4) & ~32'h20,       1'b0};
        vecs[2] = '{0, 1'b1, 16'd0,    12'd0, 32'd0,                  1'b1};
        vecs[3] = '{2, 1'b0, 16'd1954, 12'd0, pat(2048),              1'b0};
        vecs[4] = '{0, 1'b0, 16'd0,    12'd0, 32'd0,                  1'b1};

        ctrl_reset = 1'b1;
        start      = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        start = 1'b1;   // reset must win over start
        @(posedge clock);
        #1;
        check("reset_flags", {busy, done, pass, mem_wren}, 0);
        check("reset_err", {err_count, first_err_addr, first_err_data}, 0);
        check("reset_mem_port", {mem_address, mem_data}, 0);
        @(negedge clock);
        start      = 1'b0;
        ctrl_reset = 1'b0;
        @(negedge clock);
        check("idle_after_reset", {busy, mem_wren}, 0);

        for (int i = 0; i < 5; i++) run_test(vecs[i]);

        // reset roughly 100 cycles into the first read pass
        fault_mode = 0;
        wq.delete();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        start = 1'b0;
        repeat (2100) @(negedge clock);
        check("in_read_phase", {busy, mem_wren}, 2'b10);
        ctrl_reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_flags", {busy, done, pass, mem_wren}, 0);
        check("midrst_err_count", err_count, 0);
        check("midrst_first_addr", first_err_addr, 0);
        check("midrst_first_data", first_err_data, 0);
        check("midrst_mem_address", mem_address, 0);
        check("midrst_mem_data", mem_data, 0);
        @(negedge clock);
        ctrl_reset = 1'b0;
        repeat (5) @(negedge clock);
        check("midrst_stays_idle", {busy, done, mem_wren}, 0);
        run_test(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
